// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared register-file write-port widths and request record
package wb_port_arbiter_pkg;
  localparam int REG_CNT = 16;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_port_arbiter_scoreboard.sv
// wb_scoreboard: bitmap of registers with an outstanding long-latency write
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  output logic [REG_CNT-1:0]    pending
);
  // set is applied after clear so a retire and re-issue of one register leaves it pending
  always_ff @(posedge clk)
    if (!rst || flush) pending <= '0;
    else pending <= (pending & ~(REG_CNT'(clr_en) << clr_idx)) | (REG_CNT'(set_en) << set_idx);
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline and the long-latency unit
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_ready,
  input  logic                  b_issue,
  input  logic [REG_ADDR_W-1:0] b_issue_dest,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_ready,
  output logic                  writeBackEn,
  output logic [REG_ADDR_W-1:0] Dest_wb,
  output logic [DATA_W-1:0]     Result_WB,
  output logic [REG_CNT-1:0]    pending
);
  logic [3:0] wait_cnt;
  logic a_blocked, force_b;
  // A yields when its target still has an older B write in flight
  always_comb begin
    a_blocked = a_valid & pending[a_dest];
    force_b = b_valid & (wait_cnt == 4'(MAX_WAIT));
    b_ready = rst & ~flush & b_valid & (force_b | ~a_valid | a_blocked);
    a_ready = rst & ~flush & a_valid & ~a_blocked & ~b_ready;
  end
  always_ff @(posedge clk)
    if (!rst || !b_valid || b_ready || flush) wait_cnt <= '0;
    else if (wait_cnt != 4'(MAX_WAIT)) wait_cnt <= wait_cnt + 4'd1;
  always_ff @(posedge clk)
    if (!rst) begin
      writeBackEn <= 1'b0;
      Dest_wb <= '0;
      Result_WB <= '0;
    end else begin
      writeBackEn <= a_ready | b_ready;
      if (b_ready) begin
        Dest_wb <= b_dest;
        Result_WB <= b_data;
      end else if (a_ready) begin
        Dest_wb <= a_dest;
        Result_WB <= a_data;
      end
    end
  wb_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .clr_en(b_ready),
    .clr_idx(b_dest),
    .set_en(b_issue),
    .set_idx(b_issue_dest),
    .pending(pending)
  );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table plus reset sequences for the write-port arbiter
module tb_wb_port_arbiter;
  logic clk = 0, rst = 0, flush = 0;
  logic a_valid = 0, b_valid = 0, b_issue = 0;
  logic [3:0] a_dest = 0, b_dest = 0, b_issue_dest = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, writeBackEn;
  logic [3:0] Dest_wb;
  logic [31:0] Result_WB;
  logic [15:0] pending;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.MAX_WAIT(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
    .b_issue(b_issue), .b_issue_dest(b_issue_dest),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB), .pending(pending)
  );

  typedef struct {
    logic av; logic [3:0] ad; logic [31:0] adat;
    logic bv; logic [3:0] bd; logic [31:0] bdat;
    logic bi; logic [3:0] bid; logic fl;
    logic ear; logic ebr;
    logic ewen; logic [3:0] edst; logic [31:0] eres; logic [15:0] epend;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(logic av, logic [3:0] ad, logic [31:0] adat,
                              logic bv, logic [3:0] bd, logic [31:0] bdat,
                              logic bi, logic [3:0] bid, logic fl,
                              logic ear, logic ebr,
                              logic ewen, logic [3:0] edst, logic [31:0] eres, logic [15:0] epend);
    vec_t r;
    r.av = av; r.ad = ad; r.adat = adat; r.bv = bv; r.bd = bd; r.bdat = bdat;
    r.bi = bi; r.bid = bid; r.fl = fl; r.ear = ear; r.ebr = ebr;
    r.ewen = ewen; r.edst = edst; r.eres = eres; r.epend = epend;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // reset held with both requesters active and an issue attempt
    @(negedge clk);
    rst = 0; a_valid = 1; b_valid = 1; a_dest = 4'd2; b_dest = 4'd4; b_issue = 1; b_issue_dest = 4'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("rst%0d a_ready", i), 32'(a_ready), 0);
      chk($sformatf("rst%0d b_ready", i), 32'(b_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("rst%0d wen", i), 32'(writeBackEn), 0);
      chk($sformatf("rst%0d dest", i), 32'(Dest_wb), 0);
      chk($sformatf("rst%0d res", i), Result_WB, 0);
      chk($sformatf("rst%0d pend", i), 32'(pending), 0);
      @(negedge clk);
    end
    rst = 1;
    //        av ad  adat          bv bd  bdat          bi bid fl  ar br  wen dst res           pend
    v.push_back(mk(1, 3, 32'h1234,     0, 0, 0,            0, 0, 0,  1, 0,  1, 3, 32'h1234,     16'h0000));
    v.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 0,  0, 3, 32'h1234,     16'h0000));
    for (int i = 0; i < 4; i++)
      v.push_back(mk(1, 1, 32'h100 + i, 1, 2, 32'hBBBB,    0, 0, 0,  1, 0,  1, 1, 32'h100 + i,  16'h0000));
    v.push_back(mk(1, 1, 32'h104,      1, 2, 32'hBBBB,     0, 0, 0,  0, 1,  1, 2, 32'hBBBB,     16'h0000));
    v.push_back(mk(1, 1, 32'h105,      1, 2, 32'hBBBC,     0, 0, 0,  1, 0,  1, 1, 32'h105,      16'h0000));
    v.push_back(mk(0, 0, 0,            1, 2, 32'hBBBC,     0, 0, 0,  0, 1,  1, 2, 32'hBBBC,     16'h0000));
    v.push_back(mk(0, 0, 0,            0, 0, 0,            1, 5, 0,  0, 0,  0, 2, 32'hBBBC,     16'h0020));
    v.push_back(mk(1, 5, 32'h55,       0, 0, 0,            0, 0, 0,  0, 0,  0, 2, 32'hBBBC,     16'h0020));
    v.push_back(mk(1, 5, 32'h55,       1, 5, 32'h5B,       0, 0, 0,  0, 1,  1, 5, 32'h5B,       16'h0000));
    v.push_back(mk(1, 5, 32'h55,       0, 0, 0,            0, 0, 0,  1, 0,  1, 5, 32'h55,       16'h0000));
    v.push_back(mk(0, 0, 0,            0, 0, 0,            1, 7, 0,  0, 0,  0, 5, 32'h55,       16'h0080));
    v.push_back(mk(0, 0, 0,            1, 7, 32'h77,       1, 7, 0,  0, 1,  1, 7, 32'h77,       16'h0080));
    v.push_back(mk(0, 0, 0,            0, 0, 0,            1, 5, 0,  0, 0,  0, 7, 32'h77,       16'h00A0));
    for (int i = 0; i < 3; i++)
      v.push_back(mk(1, 1, 32'hA0 + i, 1, 9, 32'h99,       0, 0, 0,  1, 0,  1, 1, 32'hA0 + i,   16'h00A0));
    v.push_back(mk(1, 1, 32'hAF,       1, 9, 32'h99,       1, 2, 1,  0, 0,  0, 1, 32'hA2,       16'h0000));
    v.push_back(mk(1, 5, 32'h5A5A,     1, 9, 32'h99,       0, 0, 0,  1, 0,  1, 5, 32'h5A5A,     16'h0000));
    for (int i = 0; i < v.size(); i++) begin
      a_valid = v[i].av; a_dest = v[i].ad; a_data = v[i].adat;
      b_valid = v[i].bv; b_dest = v[i].bd; b_data = v[i].bdat;
      b_issue = v[i].bi; b_issue_dest = v[i].bid; flush = v[i].fl;
      #1;
      chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(v[i].ear));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(v[i].ebr));
      @(posedge clk); #1;
      chk($sformatf("v%0d wen", i), 32'(writeBackEn), 32'(v[i].ewen));
      chk($sformatf("v%0d dest", i), 32'(Dest_wb), 32'(v[i].edst));
      chk($sformatf("v%0d res", i), Result_WB, v[i].eres);
      chk($sformatf("v%0d pend", i), 32'(pending), 32'(v[i].epend));
      @(negedge clk);
    end
    // reset arriving mid-operation drops the grant made in that cycle
    a_valid = 1; a_dest = 4'd6; a_data = 32'h66; b_valid = 0; b_issue = 1; b_issue_dest = 4'd6; flush = 0;
    #1;
    chk("pre-rst a_ready", 32'(a_ready), 1);
    rst = 0;
    #1;
    chk("mid-rst a_ready", 32'(a_ready), 0);
    @(posedge clk); #1;
    chk("mid-rst wen", 32'(writeBackEn), 0);
    chk("mid-rst dest", 32'(Dest_wb), 0);
    chk("mid-rst res", Result_WB, 0);
    chk("mid-rst pend", 32'(pending), 0);
    @(negedge clk);
    rst = 1; b_issue = 0;
    #1;
    chk("post-rst a_ready", 32'(a_ready), 1);
    @(posedge clk); #1;
    chk("post-rst dest", 32'(Dest_wb), 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
